// File: rtl/gon_rr_bus.sv
// gon_rr_bus: buffered GON bus stage. Gathers beats from NUM_MASTER masters
// whose scan-loaded ID matches the broadcast tag, arbitrates among eligible
// masters and queues accepted beats in a FIFO_DEPTH-entry output buffer.
// Optional feature macro: GON_RR_ARB_EN (round-robin arbitration); when it is
// undefined the lowest eligible index wins.
module gon_rr_bus #(
   parameter int NUM_MASTER = 8,
   parameter int ID_BITS    = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ID_BITS-1:0]           tag,
   input  logic                         set_id,
   input  logic [ID_BITS-1:0]           id_scan_in,
   output logic [ID_BITS-1:0]           id_scan_out,
   input  logic [NUM_MASTER-1:0]        master_valid,
   output logic [NUM_MASTER-1:0]        master_ready,
   input  logic [NUM_MASTER*DATA_W-1:0] master_data,
   output logic                         slave_valid,
   input  logic                         slave_ready,
   output logic [DATA_W-1:0]            slave_data
);

   localparam int PTR_W = $clog2(NUM_MASTER);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = $clog2(FIFO_DEPTH + 1);

   logic [ID_BITS-1:0]    id [NUM_MASTER];
   logic [NUM_MASTER-1:0] elig;
   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      gnt_idx;
   logic                  gnt_found;
   logic [DATA_W-1:0]     push_data;
   logic [DATA_W-1:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  push;
   logic                  pop;

   // ID scan chain: shifts toward the highest master index while set_id is high
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned k = 0; k < NUM_MASTER; k++) id[k] <= '0;
      end else if (set_id) begin
         id[0] <= id_scan_in;
         for (int unsigned k = 1; k < NUM_MASTER; k++) id[k] <= id[k-1];
      end
   end

   assign id_scan_out = id[NUM_MASTER-1];

   // Eligibility: valid master whose ID matches the tag, suppressed during scan
   always_comb begin
      elig = '0;
      for (int unsigned k = 0; k < NUM_MASTER; k++)
         elig[k] = master_valid[k] & (id[k] == tag) & ~set_id;
   end

   // Grant search: first eligible index at or above ptr, wrapping to 0
   always_comb begin
      int unsigned k;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      push_data = '0;
      k         = 0;
      for (int unsigned i = 0; i < NUM_MASTER; i++) begin
         k = (32'(ptr) + i) % NUM_MASTER;
         if (!gnt_found && elig[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(k);
            push_data = master_data[DATA_W*k +: DATA_W];
         end
      end
   end

   assign full = (count == CW'(FIFO_DEPTH));

   // Ready to the granted master only; uses registered full so slave_ready
   // has no combinational path here
   always_comb begin
      master_ready = '0;
      if (rst && gnt_found && !full) master_ready[gnt_idx] = 1'b1;
   end

   assign push = |master_ready;
   assign pop  = slave_valid & slave_ready;

`ifdef GON_RR_ARB_EN
   // Round-robin pointer: moves past the master that just transferred
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= '0;
      end else if (push) begin
         ptr <= (gnt_idx == PTR_W'(NUM_MASTER - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end
`else
   assign ptr = '0;
`endif

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; push is already blocked during reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign slave_valid = (count != '0);
   assign slave_data  = mem[rd_ptr];

endmodule
